alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Upstream stage of the 8-bit ALU: accepts operation commands over a valid/ready port and buffers them in a FIFO.
//  Issues one command at a time onto the ALU input pins and waits the ALU latency, then captures alu_out.
//  Services the ALU interrupt (alu_irq / alu_irq_clr) and returns each result on a valid/ready response port.
// PARAMETERS
//  DEPTH    4  command FIFO entries; power of two, >=2
//  ALU_LAT  1  alu_clk edges from inputs stable until alu_out valid; >=1
// PORTS
//  alu_clk      in   1               clock, all logic on rising edge
//  rst_n        in   1               asynchronous reset, active-low
//  cmd_valid    in   1               command present
//  cmd_ready    out  1               FIFO not full
//  cmd_a        in   8               operand A
//  cmd_b        in   8               operand B
//  cmd_mode     in   operation_mode  ALU mode select
//  cmd_op_a     in   alu_op_a        op code, A-mode set
//  cmd_op_b     in   alu_op_b        op code, B-mode set
//  alu_in_a     out  8               to ALU operand A
//  alu_in_b     out  8               to ALU operand B
//  alu_mode     out  operation_mode  to ALU
//  alu_op_a     out  alu_op_a        to ALU
//  alu_op_b     out  alu_op_b        to ALU
//  alu_irq_clr  out  1               to ALU, interrupt clear
//  alu_out      in   8               from ALU result
//  alu_irq      in   1               from ALU interrupt
//  rsp_valid    out  1               result available
//  rsp_ready    in   1               consumer accepts result
//  rsp_data     out  8               captured alu_out
//  rsp_irq      out  1               alu_irq was high when this result was captured
//  irq_count    out  8               interrupts seen since reset, saturates at 255
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, FIFO empty, cmd_ready=1. All ALU-side outputs 0 (enums take their first literal).
//   rsp_valid=0, rsp_data=0, rsp_irq=0, irq_count=0. Any in-flight op is dropped with no response.
//  FIFO push on cmd_valid&&cmd_ready. cmd_ready=!full. Pointers wrap at DEPTH.
//   Push and pop in the same cycle leave the count unchanged.
//  FSM states IDLE, WAIT, SAMPLE, IRQ_CLR, RESP:
//   IDLE: if FIFO not empty, at this edge load alu_* regs from the head, pop, load cnt=ALU_LAT, go to WAIT.
//   WAIT: decrement cnt; when cnt==1, go to SAMPLE.
//   SAMPLE: alu_out is valid. Register rsp_data<=alu_out and rsp_irq<=alu_irq.
//    If alu_irq=1, increment irq_count (saturating) and go to IRQ_CLR; otherwise go to RESP.
//   IRQ_CLR: alu_irq_clr=1 (registered) for as long as the state holds. Go to RESP on the first cycle alu_irq=0.
//    alu_irq_clr drops in the same edge.
//   RESP: rsp_valid=1 and rsp_data/rsp_irq stable. On rsp_ready, go to IDLE and set rsp_valid=0 next cycle.
//  alu_in_*/alu_mode/alu_op_* change only at the issue edge; they hold between ops.
//  Latency, accept to rsp_valid, no irq: 3+ALU_LAT cycles (4 at default). Max one op in flight.
//  Backpressure on rsp stalls issue; the FIFO keeps accepting until full.
//  alu_irq rising outside SAMPLE is ignored until the next SAMPLE; it is never cleared spontaneously.
// STRUCTURE
//  alu_pkg (shared): operation_mode, alu_op_a, alu_op_b enums; cmd struct {a,b,mode,op_a,op_b}; seq_state_e.
//  Sub-module alu_cmd_fifo: parameterised DEPTH, cmd-struct payload, full/empty flags.
//  Top holds the FSM, latency counter, response regs and irq counter.
// TESTING
//  Reset, then one cmd a=8'h05, b=8'h03 with a model ALU (out=a+b, LAT=1):
//   alu_in_a=05 two cycles after accept, rsp_valid on cycle 4, rsp_data=08, rsp_irq=0.
//  Push 5 cmds back-to-back with rsp_ready=0, DEPTH=4:
//   cmd_ready drops after the 5th accept (4 buffered + 1 issued). Raise rsp_ready: 5 responses in order, none lost.
//  Model ALU asserts alu_irq in SAMPLE and holds it 3 cycles after alu_irq_clr:
//   alu_irq_clr high 3 cycles, then rsp_valid with rsp_irq=1, irq_count=1.
//  rst_n low while in WAIT: outputs zero immediately, no response.
//   After release, a new cmd completes normally.
//  Sweep ALU_LAT=1,3: rsp latency = 4 and 6 cycles.
//   256 irq ops give irq_count=255 (saturated).
//  Simultaneous push/pop with one entry in the FIFO: count stays 1 and order is preserved.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU command types, sequencer states and helpers
package alu_pkg;

  typedef enum logic {
    MODE_A = 1'b0,
    MODE_B = 1'b1
  } operation_mode;

  typedef enum logic [1:0] {
    OPA_AND = 2'd0,
    OPA_OR  = 2'd1,
    OPA_XOR = 2'd2,
    OPA_ADD = 2'd3
  } alu_op_a;

  typedef enum logic [1:0] {
    OPB_SUB  = 2'd0,
    OPB_NAND = 2'd1,
    OPB_SHL  = 2'd2,
    OPB_SHR  = 2'd3
  } alu_op_b;

  typedef struct packed {
    logic [7:0]    a;
    logic [7:0]    b;
    operation_mode mode;
    alu_op_a       op_a;
    alu_op_b       op_b;
  } alu_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_SAMPLE  = 3'd2,
    ST_IRQ_CLR = 3'd3,
    ST_RESP    = 3'd4
  } seq_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - command FIFO, power-of-two depth, carries one alu_cmd_t per entry
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  alu_cmd_t wdata_i,
  input  logic     pop_i,
  output alu_cmd_t rdata_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int AW = $clog2(DEPTH);

  alu_cmd_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  logic            push_ok;
  logic            pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - buffers ALU commands, issues one at a time, services irq, returns results
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic          alu_clk,
  input  logic          rst_n,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [7:0]    cmd_a_i,
  input  logic [7:0]    cmd_b_i,
  input  operation_mode cmd_mode_i,
  input  alu_op_a       cmd_op_a_i,
  input  alu_op_b       cmd_op_b_i,
  output logic [7:0]    alu_in_a_o,
  output logic [7:0]    alu_in_b_o,
  output operation_mode alu_mode_o,
  output alu_op_a       alu_op_a_o,
  output alu_op_b       alu_op_b_o,
  output logic          alu_irq_clr_o,
  input  logic [7:0]    alu_out_i,
  input  logic          alu_irq_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [7:0]    rsp_data_o,
  output logic          rsp_irq_o,
  output logic [7:0]    irq_count_o
);

  localparam int CW = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

  seq_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    alu_a_q;
  logic [7:0]    alu_b_q;
  operation_mode alu_mode_q;
  alu_op_a       alu_op_a_q;
  alu_op_b       alu_op_b_q;
  logic          irq_clr_q;
  logic          rsp_valid_q;
  logic [7:0]    rsp_data_q;
  logic          rsp_irq_q;
  logic [7:0]    irq_count_q;
  logic [7:0]    irq_count_d;

  alu_cmd_t      cmd_in;
  alu_cmd_t      head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;

  assign cmd_in      = '{a: cmd_a_i, b: cmd_b_i, mode: cmd_mode_i,
                         op_a: cmd_op_a_i, op_b: cmd_op_b_i};
  assign cmd_ready_o = !fifo_full;
  assign pop         = (state_q == ST_IDLE) && !fifo_empty;
  assign irq_count_d = sat_inc8(irq_count_q);

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (alu_clk),
    .rst_n   (rst_n),
    .push_i  (cmd_valid_i),
    .wdata_i (cmd_in),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_mode_q  <= MODE_A;
      alu_op_a_q  <= OPA_AND;
      alu_op_b_q  <= OPB_SUB;
      irq_clr_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_irq_q   <= 1'b0;
      irq_count_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            alu_a_q    <= head.a;
            alu_b_q    <= head.b;
            alu_mode_q <= head.mode;
            alu_op_a_q <= head.op_a;
            alu_op_b_q <= head.op_b;
            cnt_q      <= CW'(ALU_LAT);
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          rsp_data_q <= alu_out_i;
          rsp_irq_q  <= alu_irq_i;
          if (alu_irq_i) begin
            irq_count_q <= irq_count_d;
            irq_clr_q   <= 1'b1;
            state_q     <= ST_IRQ_CLR;
          end else begin
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        // Hold the clear until the ALU actually drops its interrupt.
        ST_IRQ_CLR: begin
          if (!alu_irq_i) begin
            irq_clr_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign alu_in_a_o    = alu_a_q;
  assign alu_in_b_o    = alu_b_q;
  assign alu_mode_o    = alu_mode_q;
  assign alu_op_a_o    = alu_op_a_q;
  assign alu_op_b_o    = alu_op_b_q;
  assign alu_irq_clr_o = irq_clr_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_irq_o     = rsp_irq_q;
  assign irq_count_o   = irq_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed bench for alu_cmd_sequencer with a model adder ALU
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  logic          alu_clk = 1'b0;
  logic          rst_n;

  logic          cmd_valid, cmd_ready;
  logic [7:0]    cmd_a, cmd_b;
  operation_mode cmd_mode;
  alu_op_a       cmd_op_a;
  alu_op_b       cmd_op_b;
  logic [7:0]    alu_in_a, alu_in_b, alu_out;
  operation_mode alu_mode;
  alu_op_a       alu_opa;
  alu_op_b       alu_opb;
  logic          alu_irq_clr, alu_irq;
  logic          rsp_valid, rsp_ready, rsp_irq;
  logic [7:0]    rsp_data, irq_count;

  logic          c3_valid, c3_ready;
  logic [7:0]    c3_in_a, c3_in_b, c3_out;
  operation_mode c3_mode;
  alu_op_a       c3_opa;
  alu_op_b       c3_opb;
  logic          c3_irq_clr, c3_irq;
  logic          c3_rsp_valid, c3_rsp_ready, c3_rsp_irq;
  logic [7:0]    c3_rsp_data, c3_irq_count;

  logic          irq_arm;
  logic [1:0]    irq_cnt;
  int            n_checks = 0;
  int            n_pass   = 0;

  always #5 alu_clk = ~alu_clk;

  alu_cmd_sequencer #(.DEPTH(4), .ALU_LAT(1)) u_dut (
    .alu_clk(alu_clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_mode_i(cmd_mode),
    .cmd_op_a_i(cmd_op_a), .cmd_op_b_i(cmd_op_b),
    .alu_in_a_o(alu_in_a), .alu_in_b_o(alu_in_b), .alu_mode_o(alu_mode),
    .alu_op_a_o(alu_opa), .alu_op_b_o(alu_opb), .alu_irq_clr_o(alu_irq_clr),
    .alu_out_i(alu_out), .alu_irq_i(alu_irq),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_irq_o(rsp_irq), .irq_count_o(irq_count)
  );

  alu_cmd_sequencer #(.DEPTH(4), .ALU_LAT(3)) u_dut3 (
    .alu_clk(alu_clk), .rst_n(rst_n),
    .cmd_valid_i(c3_valid), .cmd_ready_o(c3_ready),
    .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_mode_i(cmd_mode),
    .cmd_op_a_i(cmd_op_a), .cmd_op_b_i(cmd_op_b),
    .alu_in_a_o(c3_in_a), .alu_in_b_o(c3_in_b), .alu_mode_o(c3_mode),
    .alu_op_a_o(c3_opa), .alu_op_b_o(c3_opb), .alu_irq_clr_o(c3_irq_clr),
    .alu_out_i(c3_out), .alu_irq_i(c3_irq),
    .rsp_valid_o(c3_rsp_valid), .rsp_ready_i(c3_rsp_ready),
    .rsp_data_o(c3_rsp_data), .rsp_irq_o(c3_rsp_irq), .irq_count_o(c3_irq_count)
  );

  assign alu_out = alu_in_a + alu_in_b;
  assign c3_out  = c3_in_a + c3_in_b;
  assign c3_irq  = 1'b0;

  // Model ALU interrupt: raised while armed, dropped after seeing the clear for 2 edges.
  always @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_irq <= 1'b0;
      irq_cnt <= 2'd0;
    end else if (alu_irq && alu_irq_clr) begin
      if (irq_cnt == 2'd1) begin
        alu_irq <= 1'b0;
        irq_cnt <= 2'd0;
      end else begin
        irq_cnt <= irq_cnt + 2'd1;
      end
    end else if (!alu_irq && irq_arm) begin
      alu_irq <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    cmd_a = a;
    cmd_b = b;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(posedge alu_clk); #1; n++;
    end
    if (n >= 50) check("push_timeout", {31'd0, cmd_ready}, 32'd1);
    @(posedge alu_clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [7:0] d, output logic irq, output logic ok);
    int n = 0;
    rsp_ready = 1'b1;
    while (!rsp_valid && n < 50) begin
      @(posedge alu_clk); #1; n++;
    end
    ok  = rsp_valid;
    d   = rsp_data;
    irq = rsp_irq;
    @(posedge alu_clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic       ri, ok;
    int         lat, n_clr, n_seen, n_bad;

    rst_n = 1'b0;
    cmd_valid = 1'b0; c3_valid = 1'b0;
    rsp_ready = 1'b0; c3_rsp_ready = 1'b0;
    cmd_a = 8'h00; cmd_b = 8'h00;
    cmd_mode = MODE_B; cmd_op_a = OPA_ADD; cmd_op_b = OPB_SHL;
    irq_arm = 1'b0;

    repeat (3) @(posedge alu_clk);
    #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    check("rst_alu_in_a", {24'd0, alu_in_a}, 32'd0);
    check("rst_alu_op_a", {30'd0, alu_opa}, 32'd0);
    check("rst_irq_clr", {31'd0, alu_irq_clr}, 32'd0);
    check("rst_irq_count", {24'd0, irq_count}, 32'd0);
    rst_n = 1'b1;
    @(posedge alu_clk); #1;

    // Single op: 05 + 03, latency counted with the accept edge as 1.
    cmd_a = 8'h05; cmd_b = 8'h03; cmd_valid = 1'b1;
    @(posedge alu_clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 30) begin
      @(posedge alu_clk); #1; lat++;
      if (lat == 2) begin
        check("issue_alu_in_a", {24'd0, alu_in_a}, 32'h05);
        check("issue_alu_mode", {31'd0, alu_mode}, {31'd0, MODE_B});
      end
    end
    check("lat1_latency", lat, 4);
    check("lat1_rsp_data", {24'd0, rsp_data}, 32'h08);
    check("lat1_rsp_irq", {31'd0, rsp_irq}, 32'd0);
    rsp_ready = 1'b1;
    @(posedge alu_clk); #1;
    rsp_ready = 1'b0;
    check("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);

    // Five back-to-back commands with response backpressure.
    for (int i = 0; i < 5; i++) begin
      push(8'h10 * 8'(i) + 8'h01, 8'h02);
      if (i == 3) check("ready_after_4", {31'd0, cmd_ready}, 32'd1);
      if (i == 4) check("ready_after_5", {31'd0, cmd_ready}, 32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      get_rsp(d, ri, ok);
      check($sformatf("bp_ok_%0d", i), {31'd0, ok}, 32'd1);
      check($sformatf("bp_data_%0d", i), {24'd0, d}, {24'd0, 8'h10 * 8'(i) + 8'h03});
    end

    // Interrupt handshake.
    irq_arm = 1'b1;
    push(8'h20, 8'h22);
    n_clr = 0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge alu_clk); #1; lat++;
      if (alu_irq_clr) n_clr++;
    end
    irq_arm = 1'b0;
    check("irq_clr_cycles", n_clr, 3);
    check("irq_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("irq_rsp_irq", {31'd0, rsp_irq}, 32'd1);
    check("irq_rsp_data", {24'd0, rsp_data}, 32'h42);
    check("irq_count_1", {24'd0, irq_count}, 32'd1);
    get_rsp(d, ri, ok);

    // Reset while waiting on the ALU.
    push(8'h11, 8'h22);
    @(posedge alu_clk); #1;
    check("wait_alu_in_a", {24'd0, alu_in_a}, 32'h11);
    rst_n = 1'b0;
    #1;
    check("arst_alu_in_a", {24'd0, alu_in_a}, 32'd0);
    check("arst_alu_in_b", {24'd0, alu_in_b}, 32'd0);
    check("arst_irq_count", {24'd0, irq_count}, 32'd0);
    check("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("arst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (2) @(posedge alu_clk);
    #1;
    rst_n = 1'b1;
    n_seen = 0;
    repeat (8) begin
      @(posedge alu_clk); #1;
      if (rsp_valid) n_seen++;
    end
    check("arst_no_rsp", n_seen, 0);
    push(8'h30, 8'h0c);
    get_rsp(d, ri, ok);
    check("post_rst_ok", {31'd0, ok}, 32'd1);
    check("post_rst_data", {24'd0, d}, 32'h3c);

    // Push and pop on the same edge with one entry buffered.
    push(8'h01, 8'h01);
    push(8'h02, 8'h02);
    check("pushpop_count", {29'd0, u_dut.u_fifo.count_q}, 32'd1);
    get_rsp(d, ri, ok);
    check("pushpop_first", {24'd0, d}, 32'h02);
    get_rsp(d, ri, ok);
    check("pushpop_second", {24'd0, d}, 32'h04);

    // 256 interrupting ops: counter saturates at 255.
    irq_arm = 1'b1;
    n_seen = 0;
    n_bad = 0;
    for (int i = 0; i < 256; i++) begin
      push(8'(i), 8'h01);
      get_rsp(d, ri, ok);
      if (ok && ri) n_seen++;
      if (!ok || d !== 8'(i + 1)) n_bad++;
      if (i == 254) check("irq_count_255", {24'd0, irq_count}, 32'd255);
    end
    irq_arm = 1'b0;
    check("sat_irq_rsps", n_seen, 256);
    check("sat_data_errs", n_bad, 0);
    check("irq_count_sat", {24'd0, irq_count}, 32'd255);

    // ALU_LAT=3 instance.
    cmd_a = 8'h07; cmd_b = 8'h09; c3_valid = 1'b1;
    @(posedge alu_clk); #1;
    c3_valid = 1'b0;
    lat = 1;
    while (!c3_rsp_valid && lat < 30) begin
      @(posedge alu_clk); #1; lat++;
    end
    check("lat3_latency", lat, 6);
    check("lat3_rsp_data", {24'd0, c3_rsp_data}, 32'h10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
